buffer_read_streamer: RTL

//  Read-side master for one SRAM buffer (unified or weighting buffer).

---
 rtl/buffer_read_streamer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/buffer_read_streamer.sv
// Read-side streamer for one SRAM buffer: sequential word reads,
// credit-limited so the output FIFO absorbs the 1-cycle read latency.
module buffer_read_streamer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [15:0]       cmd_len,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_do,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic              inf_q, inf_last_q;
  logic              zlen_q, zlen_d;
  logic              rdy_q;

  logic [DATA_W-1:0] mem_q  [FIFO_DEPTH];
  logic              last_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;

  logic issue, issue_last, push, pop, credit_ok, drain_done;

  // Credits count words already queued plus the one still in the SRAM.
  assign credit_ok = ({1'b0, cnt_q} + (CW+1)'(inf_q))
                     < (CW+1)'(FIFO_DEPTH);

  assign push      = inf_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign out_last  = last_q[rptr_q];
  assign pop       = out_valid && out_ready;

  assign sram_wen  = 1'b0;
  assign sram_addr = addr_q;
  assign busy      = (state_q != IDLE);
  assign cmd_ready = rdy_q && (state_q == IDLE);
  assign done      = drain_done || zlen_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    zlen_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_len == 16'd0) begin
            zlen_d = 1'b1;
          end else begin
            addr_d  = cmd_base & ~ADDR_W'(3);
            rem_d   = cmd_len;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(4);
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((cnt_q == '0) && !inf_q) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      zlen_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inf_q      <= issue;
      inf_last_q <= issue_last;
      zlen_q     <= zlen_d;
      rdy_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q]  <= sram_do;
        last_q[wptr_q] <= inf_last_q;
        wptr_q <= (wptr_q == PW'(FIFO_DEPTH-1))
                  ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(FIFO_DEPTH-1))
                  ? '0 : rptr_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule
